weight_store: RTL and testbench
===============================

WEIGHT_STORE -- requirements
Module: weight_store

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning width of the weight address.
REQ-002 SHALL have parameter DW, default 8, meaning width of the weight word, holding two signed 4-bit nibbles.
REQ-003 SHALL have these ports, clock and reset first:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- w_req  input  1  read request from the inference engine.
- w_addr  input  ADDR_W  read address, valid with w_req.
- w_valid  output  1  one-cycle read-data-valid strobe.
- w_data  output  DW  read data, valid when w_valid=1.
- load_en  input  1  host write strobe.
- load_addr  input  ADDR_W  host write address.
- load_data  input  DW  host write data.
- upd_start  input  1  one-cycle pulse that starts a reward update.
- upd_addr  input  ADDR_W  word to update, sampled with upd_start.
- reward  input  2  reward code, sampled with upd_start: 01=+1, 11=-1, 00/10=no change.
- upd_busy  output  1  update in progress.
- upd_done  output  1  one-cycle update-complete pulse.

Function
REQ-004 SHALL hold 2**ADDR_W words of DW bits in registers; word[7:4] is hi nibble, word[3:0] is lo nibble, both signed two's complement.
REQ-005 SHALL assert w_valid exactly one cycle after each cycle with w_req=1, with w_data = word at w_addr as stored before any write in the request cycle.
REQ-006 SHALL accept back-to-back w_req every cycle, giving one w_valid per request at 1-cycle latency.
REQ-007 SHALL hold w_data at its last value while w_valid=0.
REQ-008 SHALL serve reads in every update FSM state; reads are never stalled.
REQ-009 SHALL, when load_en=1 and upd_busy=0, write load_data to load_addr at that clock edge.
REQ-010 SHALL ignore load_en while upd_busy=1, with no write and no queuing.
REQ-011 SHALL implement update FSM states IDLE, RD, WR, DONE:
- IDLE -> RD on upd_start=1; upd_addr and reward are latched.
- RD -> WR: latched word is captured into a holding register.
- WR -> DONE: result word is written to the latched address.
- DONE -> IDLE.
REQ-012 SHALL drive upd_busy=1 in RD, WR and DONE, and upd_busy=0 in IDLE.
REQ-013 SHALL pulse upd_done for exactly one cycle while in DONE; upd_start to upd_done latency is 3 cycles.
REQ-014 SHALL ignore upd_start while upd_busy=1.
REQ-015 SHALL, in WR, set each nibble to nibble+step in 5-bit signed arithmetic, saturated to [-8,+7], where step=+1 for reward 01, -1 for 11, 0 otherwise.
REQ-016 SHALL treat reward 00/10 as a full 3-cycle update that rewrites the word unchanged and still pulses upd_done.
REQ-017 SHALL saturate each nibble independently: hi 0111 with +1 stays 0111; lo 1000 with -1 stays 1000.
REQ-018 SHALL, if upd_start is sampled in the same cycle as an accepted load_en, apply the load first and have RD capture the loaded value.
REQ-019 SHALL, for a read in the WR cycle at the updated address, return the pre-update word; a read one cycle later returns the updated word.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, set FSM=IDLE, w_valid=0, w_data=0, upd_busy=0, upd_done=0, and clear the holding and latch registers.
REQ-021 SHALL, on reset, set word0=8'h11, word1=8'h11 and all other words to 8'h00.
REQ-022 SHALL abort an in-flight update on rst, leaving the target word at its reset value; an in-flight read produces no w_valid.
REQ-023 SHALL give rst priority over load_en, upd_start and w_req in the same cycle.

Verification
REQ-024 SHALL be covered by: reset, then w_req to addr 0, 1, 2 on consecutive cycles -> w_valid on the next 3 cycles with w_data 11, 11, 00.
REQ-025 SHALL be covered by: load 8'h7F to addr 3, then upd_start with addr 3, reward 01 -> upd_done 3 cycles later; a read returns 8'h70 (hi saturated at 7, lo F+1=0).
REQ-026 SHALL be covered by: load 8'h88 to addr 4, then update with reward 11 -> word stays 8'h88; with reward 01 -> 8'h99.
REQ-027 SHALL be covered by: load_en during upd_busy to addr 5 with 8'hAA -> addr 5 unchanged; a second upd_start during busy -> only one upd_done.
REQ-028 SHALL be covered by: rst asserted in the WR cycle of an update to addr 0 -> word0 reads 8'h11, upd_done never pulses.
REQ-029 SHALL be covered by: upd_start with reward 00 on addr 1 -> upd_busy high 3 cycles, upd_done pulses once, word1 stays 8'h11.

Source files
------------

// File: rtl/weight_store.sv
// Register-file weight store with a 1-cycle read port, a host load port and a
// 3-cycle read-modify-write reward update that saturates two signed nibbles.
module weight_store #(
    parameter int ADDR_W = 4,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              w_valid,
    output logic [DW-1:0]     w_data,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DW-1:0]     load_data,
    input  logic              upd_start,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [1:0]        reward,
    output logic              upd_busy,
    output logic              upd_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NW    = DW / 2;
    localparam logic [DW-1:0] INIT_WORD = {(DW / 4){4'h1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic [DW-1:0]       mem [DEPTH];
    logic [ADDR_W-1:0]   lat_addr;
    logic [1:0]          lat_reward;
    logic [DW-1:0]       hold;
    logic [1:0]          step;
    logic [DW-1:0]       upd_word;

    // Step is +1/-1 in two's complement; the sum fits NW+1 bits, so overflow
    // is exactly the case where the top two bits of the sum disagree.
    function automatic logic [NW-1:0] sat_add(input logic [NW-1:0] n,
                                              input logic [1:0]    s);
        logic [NW:0] sum;
        sum = {n[NW-1], n} + {{(NW - 1){s[1]}}, s};
        if (sum[NW] != sum[NW-1])
            sat_add = sum[NW] ? {1'b1, {(NW - 1){1'b0}}} : {1'b0, {(NW - 1){1'b1}}};
        else
            sat_add = sum[NW-1:0];
    endfunction

    always_comb begin
        step = 2'b00;
        case (lat_reward)
            2'b01:   step = 2'b01;
            2'b11:   step = 2'b11;
            default: step = 2'b00;
        endcase
        upd_word = {sat_add(hold[DW-1:NW], step), sat_add(hold[NW-1:0], step)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            upd_busy   <= 1'b0;
            upd_done   <= 1'b0;
            lat_addr   <= '0;
            lat_reward <= '0;
            hold       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= (i < 2) ? INIT_WORD : '0;
        end else begin
            upd_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Loads are only accepted here, so they never collide with the WR write.
                    if (load_en)
                        mem[load_addr] <= load_data;
                    if (upd_start) begin
                        lat_addr   <= upd_addr;
                        lat_reward <= reward;
                        upd_busy   <= 1'b1;
                        state      <= RD;
                    end
                end
                RD: begin
                    hold  <= mem[lat_addr];
                    state <= WR;
                end
                WR: begin
                    mem[lat_addr] <= upd_word;
                    upd_done      <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    upd_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    upd_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid <= 1'b0;
            w_data  <= '0;
        end else begin
            w_valid <= w_req;
            if (w_req)
                w_data <= mem[w_addr];
        end
    end

endmodule

// File: tb/tb_weight_store.sv
// Directed self-checking bench for weight_store: reads, loads, reward updates,
// saturation, busy-time blocking and reset abort.
module tb_weight_store;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_req = 1'b0;
    logic [3:0] w_addr = '0;
    logic       w_valid;
    logic [7:0] w_data;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       upd_start = 1'b0;
    logic [3:0] upd_addr = '0;
    logic [1:0] reward = '0;
    logic       upd_busy;
    logic       upd_done;

    int errors = 0;
    int checks = 0;
    int done_cnt;

    weight_store #(.ADDR_W(4), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_req     (w_req),
        .w_addr    (w_addr),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .upd_start (upd_start),
        .upd_addr  (upd_addr),
        .reward    (reward),
        .upd_busy  (upd_busy),
        .upd_done  (upd_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
        w_req  = 1'b1;
        w_addr = a;
        tick();
        w_req  = 1'b0;
        check({tag, "_valid"}, {31'd0, w_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, w_data}, {24'd0, exp});
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Runs a full update from IDLE and checks the busy/done timeline.
    task automatic update(input logic [3:0] a, input logic [1:0] r, input string tag);
        upd_start = 1'b1;
        upd_addr  = a;
        reward    = r;
        tick();
        upd_start = 1'b0;
        load_en   = 1'b0;
        check({tag, "_rd_busy"}, {31'd0, upd_busy}, 32'd1);
        check({tag, "_rd_done"}, {31'd0, upd_done}, 32'd0);
        tick();
        check({tag, "_wr_busy"}, {31'd0, upd_busy}, 32'd1);
        check({tag, "_wr_done"}, {31'd0, upd_done}, 32'd0);
        tick();
        check({tag, "_dn_busy"}, {31'd0, upd_busy}, 32'd1);
        check({tag, "_dn_done"}, {31'd0, upd_done}, 32'd1);
        tick();
        check({tag, "_idle_busy"}, {31'd0, upd_busy}, 32'd0);
        check({tag, "_idle_done"}, {31'd0, upd_done}, 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, w_valid}, 32'd0);
        check("rst_data", {24'd0, w_data}, 32'd0);
        check("rst_busy", {31'd0, upd_busy}, 32'd0);
        check("rst_done", {31'd0, upd_done}, 32'd0);

        // Back-to-back reads of the reset contents
        read_check(4'd0, 8'h11, "b2b0");
        w_req = 1'b1;
        w_addr = 4'd1;
        tick();
        check("b2b1_valid", {31'd0, w_valid}, 32'd1);
        check("b2b1_data", {24'd0, w_data}, 32'h11);
        w_addr = 4'd2;
        tick();
        w_req = 1'b0;
        check("b2b2_valid", {31'd0, w_valid}, 32'd1);
        check("b2b2_data", {24'd0, w_data}, 32'h00);
        tick();
        check("hold_valid", {31'd0, w_valid}, 32'd0);
        check("hold_data", {24'd0, w_data}, 32'h00);

        // +1 with hi saturating at 7 and lo wrapping F+1=0; read during WR sees old word
        load(4'd3, 8'h7F);
        upd_start = 1'b1;
        upd_addr  = 4'd3;
        reward    = 2'b01;
        tick();
        upd_start = 1'b0;
        tick();
        w_req  = 1'b1;
        w_addr = 4'd3;
        tick();
        check("wr_read_data", {24'd0, w_data}, 32'h7F);
        check("wr_read_done", {31'd0, upd_done}, 32'd1);
        tick();
        w_req = 1'b0;
        check("post_wr_read", {24'd0, w_data}, 32'h70);
        check("post_wr_busy", {31'd0, upd_busy}, 32'd0);
        read_check(4'd3, 8'h70, "sat_pos");

        // -8 stays -8 under -1; then +1 gives -7 per nibble
        load(4'd4, 8'h88);
        update(4'd4, 2'b11, "neg");
        read_check(4'd4, 8'h88, "sat_neg");
        update(4'd4, 2'b01, "inc");
        read_check(4'd4, 8'h99, "inc88");

        // -1 without saturation: 3-1=2, -4-1=-5
        load(4'd2, 8'h3C);
        update(4'd2, 2'b11, "dec");
        read_check(4'd2, 8'h2B, "dec3c");

        // Load and start in the same cycle: RD captures loaded word
        load_en   = 1'b1;
        load_addr = 4'd6;
        load_data = 8'h52;
        update(4'd6, 2'b01, "ldst");
        read_check(4'd6, 8'h63, "ldst");

        // Loads and restarts are ignored while busy
        done_cnt  = 0;
        upd_start = 1'b1;
        upd_addr  = 4'd5;
        reward    = 2'b00;
        tick();
        load_en   = 1'b1;
        load_addr = 4'd5;
        load_data = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) upd_start = 1'b0;
            if (i == 2) load_en = 1'b0;
            tick();
            if (upd_done) done_cnt++;
        end
        check("busy_done_cnt", done_cnt, 32'd1);
        check("busy_idle", {31'd0, upd_busy}, 32'd0);
        read_check(4'd5, 8'h00, "busy_load");

        // Reset in WR aborts the update and suppresses the read
        upd_start = 1'b1;
        upd_addr  = 4'd0;
        reward    = 2'b01;
        tick();
        upd_start = 1'b0;
        tick();
        rst    = 1'b1;
        w_req  = 1'b1;
        w_addr = 4'd0;
        tick();
        rst   = 1'b0;
        w_req = 1'b0;
        check("abort_valid", {31'd0, w_valid}, 32'd0);
        check("abort_busy", {31'd0, upd_busy}, 32'd0);
        check("abort_done", {31'd0, upd_done}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (upd_done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);
        read_check(4'd0, 8'h11, "abort_word");

        // No-change rewards are still full updates
        update(4'd1, 2'b00, "r00");
        read_check(4'd1, 8'h11, "r00");
        update(4'd1, 2'b10, "r10");
        read_check(4'd1, 8'h11, "r10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
